// File: rtl/red_pitaya_na_sweep_ctrl.sv
// Stepped-frequency network-analyzer sequencer: programs an IQ block's phase
// increment per point, polls its averager, reads the I/Q sums and streams them out.
module red_pitaya_na_sweep_ctrl #(
   parameter int PHASEBITS = 32,
   parameter int IDXBITS   = 16,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [PHASEBITS-1:0] f_start_i,
   input  logic [PHASEBITS-1:0] f_step_i,
   input  logic [IDXBITS-1:0]   points_i,
   output logic [15:0]          m_addr_o,
   output logic                 m_wen_o,
   output logic                 m_ren_o,
   output logic [31:0]          m_wdata_o,
   input  logic                 m_ack_i,
   input  logic [31:0]          m_rdata_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [61:0]          res_i_o,
   output logic [61:0]          res_q_o,
   output logic [IDXBITS-1:0]   res_idx_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   // Bus: one strobe cycle, then wait for ack (rdata valid in ack cycle).
   // Result: res_valid_o held with stable data until res_ready_i is high at a clock edge.
   localparam int CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, WR_F, POLL, RD_IL, RD_IH, RD_QL, RD_QH, OUT, FIN
   } state_t;

   state_t               state;
   state_t               bus_next;
   logic [PHASEBITS-1:0] freq;
   logic [PHASEBITS-1:0] f_step;
   logic [PHASEBITS-1:0] freq_next;
   logic [IDXBITS-1:0]   idx;
   logic [IDXBITS-1:0]   points;
   logic [30:0]          il, ih, ql, qh;
   logic [CNTW-1:0]      cnt;
   logic                 abort_q;
   logic                 abort_now;
   logic                 last_point;

   function automatic logic [15:0] addr_of(input state_t s);
      case (s)
         WR_F:    addr_of = 16'h0108;
         RD_IH:   addr_of = 16'h0144;
         RD_QL:   addr_of = 16'h0148;
         RD_QH:   addr_of = 16'h014C;
         default: addr_of = 16'h0140;
      endcase
   endfunction

   // POLL loops on itself while the averager reports busy in bit 31.
   always_comb begin
      bus_next = OUT;
      case (state)
         WR_F:    bus_next = POLL;
         POLL:    bus_next = m_rdata_i[31] ? POLL : RD_IL;
         RD_IL:   bus_next = RD_IH;
         RD_IH:   bus_next = RD_QL;
         RD_QL:   bus_next = RD_QH;
         default: bus_next = OUT;
      endcase
   end

   assign freq_next  = freq + f_step;
   assign last_point = (idx == points - IDXBITS'(1));
   assign abort_now  = abort_i | abort_q;
   assign res_i_o    = {ih, il};
   assign res_q_o    = {qh, ql};
   assign res_idx_o  = idx;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= IDLE;
         freq        <= '0;
         f_step      <= '0;
         points      <= '0;
         idx         <= '0;
         il          <= '0;
         ih          <= '0;
         ql          <= '0;
         qh          <= '0;
         cnt         <= '0;
         abort_q     <= 1'b0;
         m_addr_o    <= '0;
         m_wen_o     <= 1'b0;
         m_ren_o     <= 1'b0;
         m_wdata_o   <= '0;
         res_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         m_wen_o   <= 1'b0;
         m_ren_o   <= 1'b0;
         m_addr_o  <= '0;
         m_wdata_o <= '0;
         done_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i && !abort_i) begin
                  freq    <= f_start_i;
                  f_step  <= f_step_i;
                  points  <= points_i;
                  idx     <= '0;
                  err_o   <= 1'b0;
                  busy_o  <= 1'b1;
                  abort_q <= 1'b0;
                  if (points_i == '0) begin
                     state <= FIN;
                  end else begin
                     state     <= WR_F;
                     m_wen_o   <= 1'b1;
                     m_addr_o  <= 16'h0108;
                     m_wdata_o <= 32'(f_start_i);
                     cnt       <= '0;
                  end
               end
            end
            OUT: begin
               if (abort_i) begin
                  res_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end else if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  if (last_point) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     idx       <= idx + IDXBITS'(1);
                     freq      <= freq_next;
                     state     <= WR_F;
                     m_wen_o   <= 1'b1;
                     m_addr_o  <= 16'h0108;
                     m_wdata_o <= 32'(freq_next);
                     cnt       <= '0;
                  end
               end
            end
            FIN: begin
               busy_o <= 1'b0;
               done_o <= !abort_i;
               state  <= IDLE;
            end
            default: begin
               // Every bus state has exactly one access outstanding from entry.
               if (m_ack_i) begin
                  case (state)
                     RD_IL:   il <= m_rdata_i[30:0];
                     RD_IH:   ih <= m_rdata_i[30:0];
                     RD_QL:   ql <= m_rdata_i[30:0];
                     RD_QH:   qh <= m_rdata_i[30:0];
                     default: ;
                  endcase
                  if (abort_now) begin
                     busy_o  <= 1'b0;
                     abort_q <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     state <= bus_next;
                     if (bus_next == OUT) begin
                        res_valid_o <= 1'b1;
                     end else begin
                        m_ren_o  <= 1'b1;
                        m_addr_o <= addr_of(bus_next);
                        cnt      <= '0;
                     end
                  end
               end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                  err_o   <= 1'b1;
                  busy_o  <= 1'b0;
                  abort_q <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + CNTW'(1);
                  if (abort_i) abort_q <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_red_pitaya_na_sweep_ctrl.sv
// Bench for red_pitaya_na_sweep_ctrl: IQ register-bus model, expected-write and
// expected-result queues, monitors on the opposite clock edge.
`timescale 1ns/1ps
module tb_red_pitaya_na_sweep_ctrl;
   localparam int PB = 32;
   localparam int IB = 16;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [PB-1:0] f_start = '0;
   logic [PB-1:0] f_step = '0;
   logic [IB-1:0] points = '0;
   logic [15:0]   m_addr;
   logic          m_wen, m_ren;
   logic [31:0]   m_wdata;
   logic          m_ack = 1'b0;
   logic [31:0]   m_rdata = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [61:0]   res_i, res_q;
   logic [IB-1:0] res_idx;
   logic          busy, done, err;

   always #5 clk = ~clk;

   red_pitaya_na_sweep_ctrl #(.PHASEBITS(PB), .IDXBITS(IB), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
      .f_start_i(f_start), .f_step_i(f_step), .points_i(points),
      .m_addr_o(m_addr), .m_wen_o(m_wen), .m_ren_o(m_ren), .m_wdata_o(m_wdata),
      .m_ack_i(m_ack), .m_rdata_i(m_rdata),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_i_o(res_i), .res_q_o(res_q), .res_idx_o(res_idx),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int strobe_cnt = 0;
   int sc = 0;
   int ready_mode = 0;  // 0 random, 1 held low, 2 held high

   logic [31:0]  exp_wr_q[$];
   logic [139:0] exp_res_q[$];

   // IQ block model state
   int          avg_len = 5;
   int          avg_cnt = 0;
   int          wr_k = 0;
   int          hang_wr = -1;
   bit          fixed_sums = 1'b0;
   bit          ack_pend = 1'b0;
   bit          outstanding = 1'b0;
   logic [61:0] cur_i = '0;
   logic [61:0] cur_q = '0;
   logic [31:0] rd_next = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic fail_msg(input string name, input string what);
      n_checks++;
      $display("FAIL %s: %s", name, what);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      res_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : (ready_mode == 2);
   end

   // IQ block: acks one cycle after each strobe, averaging busy for avg_len cycles after a write.
   initial forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
         m_ack = 1'b0;
         ack_pend = 1'b0;
         avg_cnt = 0;
      end else begin
         m_ack = 1'b0;
         m_rdata = $urandom();
         if (ack_pend) begin
            m_ack = 1'b1;
            m_rdata = rd_next;
            ack_pend = 1'b0;
         end
         if (avg_cnt > 0) avg_cnt--;
         if (m_wen) begin
            strobe_cnt++;
            if (m_addr == 16'h0108) begin
               if (wr_k != hang_wr) ack_pend = 1'b1;
               rd_next = '0;
               avg_cnt = avg_len;
               if (fixed_sums) begin
                  cur_i = 62'h2_0000_0001_2345;
                  cur_q = '1;
               end else begin
                  cur_i = 62'({$urandom(), $urandom()});
                  cur_q = 62'({$urandom(), $urandom()});
               end
               exp_res_q.push_back({16'(wr_k), cur_i, cur_q});
               wr_k++;
            end
         end else if (m_ren) begin
            strobe_cnt++;
            ack_pend = 1'b1;
            case (m_addr)
               16'h0140: rd_next = {(avg_cnt > 0), cur_i[30:0]};
               16'h0144: rd_next = {1'($urandom_range(0, 1)), cur_i[61:31]};
               16'h0148: rd_next = {1'($urandom_range(0, 1)), cur_q[30:0]};
               16'h014C: rd_next = {1'($urandom_range(0, 1)), cur_q[61:31]};
               default:  rd_next = 32'hDEAD_BEEF;
            endcase
         end
      end
   end

   // Bus monitor: one access at a time, frequency writes in sweep order.
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (m_ack) outstanding = 1'b0;
         if (m_wen || m_ren) begin
            chk("single_outstanding", 64'(outstanding), 64'd0);
            outstanding = 1'b1;
            if (m_wen) begin
               if (exp_wr_q.size() == 0) fail_msg("unexpected_write", "write seen, none required");
               else begin
                  chk("wr_addr", 64'(m_addr), 64'h108);
                  chk("wr_freq", 64'(m_wdata), 64'(exp_wr_q.pop_front()));
               end
            end
         end
      end
   end

   // Result monitor
   initial begin
      logic [139:0] e;
      forever begin
         @(negedge clk);
         if (rstn && res_valid && res_ready) begin
            if (exp_res_q.size() == 0) fail_msg("unexpected_result", "result seen, none required");
            else begin
               e = exp_res_q.pop_front();
               chk("res_idx", 64'(res_idx), 64'(e[139:124]));
               chk("res_i", 64'(res_i), 64'(e[123:62]));
               chk("res_q", 64'(res_q), 64'(e[61:0]));
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rstn && done) begin
         done_cnt++;
         last_done_cyc = cyc;
         chk("busy_low_with_done", 64'(busy), 64'd0);
      end
   end

   task automatic issue_start(input logic [31:0] fs, input logic [31:0] st, input int n);
      logic [31:0] f;
      f = fs;
      for (int k = 0; k < n; k++) begin
         exp_wr_q.push_back(f);
         f = f + st;
      end
      wr_k = 0;
      @(posedge clk);
      #1;
      f_start = fs;
      f_step = st;
      points = IB'(n);
      start = 1'b1;
      sc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_sweep(input logic [31:0] fs, input logic [31:0] st, input int n,
                            input int avg, input bit fixed);
      int d0;
      int i;
      avg_len = avg;
      fixed_sums = fixed;
      d0 = done_cnt;
      issue_start(fs, st, n);
      @(negedge clk);
      chk("first_write_latency", 64'(m_wen), 64'(n != 0));
      chk("err_cleared_on_start", 64'(err), 64'd0);
      i = 0;
      while (done_cnt == d0 && i < 3000) begin
         @(posedge clk);
         i++;
      end
      if (done_cnt == d0) fail_msg("sweep_done", "no done within 3000 cycles");
      repeat (3) @(negedge clk);
      chk("done_count", 64'(done_cnt - d0), 64'd1);
      chk("busy_after_sweep", 64'(busy), 64'd0);
      chk("writes_left", 64'(exp_wr_q.size()), 64'd0);
      chk("results_left", 64'(exp_res_q.size()), 64'd0);
   endtask

   task automatic flush();
      exp_wr_q.delete();
      exp_res_q.delete();
      outstanding = 1'b0;
      hang_wr = -1;
   endtask

   initial begin
      int d0, s0, w, e, i;
      logic [61:0] si, sq;
      logic [IB-1:0] sx;
      bit stable;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_valid", 64'(res_valid), 0);
      chk("rst_strobes", 64'({m_wen, m_ren}), 0);
      chk("rst_addr_data", 64'({m_addr, m_wdata}), 0);
      chk("rst_res", 64'(res_i | res_q), 0);
      chk("rst_idx", 64'(res_idx), 0);
      @(posedge clk);
      #1 rstn = 1'b1;

      // reference sweep with known sums
      run_sweep(32'h0000_1000, 32'h0000_0100, 3, 5, 1'b1);
      // wrap of the frequency word
      run_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 3, 1'b0);
      // minimum per-point timing
      ready_mode = 2;
      run_sweep(32'h0000_4000, 32'h0000_0010, 2, 0, 1'b0);
      chk("min_sweep_cycles", 64'(last_done_cyc - sc), 64'd27);
      ready_mode = 0;
      for (int r = 0; r < 4; r++)
         run_sweep($urandom(), $urandom(), $urandom_range(1, 5), $urandom_range(0, 8), 1'b0);

      // zero points: no bus traffic, busy for one cycle, done two cycles after start
      s0 = strobe_cnt;
      d0 = done_cnt;
      issue_start(32'h1234, 32'h1, 0);
      @(negedge clk);
      chk("p0_busy", 64'(busy), 1);
      @(negedge clk);
      chk("p0_done", 64'(done), 1);
      chk("p0_busy_off", 64'(busy), 0);
      repeat (4) @(negedge clk);
      chk("p0_no_strobes", 64'(strobe_cnt - s0), 0);
      chk("p0_done_count", 64'(done_cnt - d0), 1);

      // output stall, then ack withheld at point 1
      ready_mode = 1;
      hang_wr = 1;
      avg_len = 2;
      fixed_sums = 1'b0;
      d0 = done_cnt;
      issue_start(32'h0000_2000, 32'h0000_0040, 2);
      i = 0;
      while (!res_valid && i < 200) begin
         @(negedge clk);
         i++;
      end
      if (!res_valid) fail_msg("stall_valid", "no result within 200 cycles");
      @(negedge clk);
      si = res_i;
      sq = res_q;
      sx = res_idx;
      s0 = strobe_cnt;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!res_valid || res_i !== si || res_q !== sq || res_idx !== sx) stable = 1'b0;
      end
      chk("stall_outputs_stable", 64'(stable), 1);
      chk("stall_no_bus", 64'(strobe_cnt - s0), 0);
      ready_mode = 2;
      i = 0;
      w = 0;
      while (wr_k < 2 && i < 100) begin
         @(posedge clk);
         #2;
         w = cyc;
         i++;
      end
      e = 0;
      i = 0;
      while (!err && i < 60) begin
         @(negedge clk);
         e = cyc;
         i++;
      end
      if (!err) fail_msg("timeout_err", "err_o not raised within 60 cycles");
      else chk("timeout_cycles", 64'(e - w), 64'd16);
      chk("timeout_busy", 64'(busy), 0);
      repeat (5) @(negedge clk);
      chk("err_sticky", 64'(err), 1);
      chk("timeout_no_done", 64'(done_cnt - d0), 0);
      flush();
      ready_mode = 0;

      // abort with a poll read outstanding
      avg_len = 40;
      d0 = done_cnt;
      issue_start(32'h0000_3000, 32'h0000_0100, 2);
      chk("start_clears_err", 64'(err), 0);
      i = 0;
      while (!(m_ren && m_addr == 16'h0140) && i < 50) begin
         @(posedge clk);
         #2;
         i++;
      end
      if (!(m_ren && m_addr == 16'h0140)) fail_msg("abort_poll", "no poll read within 50 cycles");
      abort = 1'b1;
      exp_wr_q.delete();
      exp_res_q.delete();
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_waits_ack", 64'(busy), 1);
      @(negedge clk);
      chk("abort_idle", 64'(busy), 0);
      s0 = strobe_cnt;
      repeat (30) @(negedge clk);
      chk("abort_no_bus", 64'(strobe_cnt - s0), 0);
      chk("abort_no_done", 64'(done_cnt - d0), 0);
      chk("abort_no_err", 64'(err), 0);
      flush();

      // abort beats start in the same cycle
      @(posedge clk);
      #1;
      points = 16'd3;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_over_start", 64'({busy, m_wen}), 0);

      // asynchronous reset mid-sweep
      avg_len = 5;
      issue_start($urandom(), $urandom(), 3);
      repeat (20) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 0);
      chk("arst_valid_done_err", 64'({res_valid, done, err}), 0);
      chk("arst_bus", 64'({m_wen, m_ren, m_addr, m_wdata}), 0);
      chk("arst_res", 64'(res_i | res_q | 62'(res_idx)), 0);
      flush();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      run_sweep($urandom(), $urandom(), 3, 4, 1'b0);
      run_sweep(32'h7FFF_FFF0, 32'h0000_0008, 4, 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish within 2 ms");
      $fatal(1);
   end

endmodule

// File: doc/red_pitaya_na_sweep_ctrl.md
# red_pitaya_na_sweep_ctrl

Sequencer that drives an IQ demodulator block's register bus to run a stepped-frequency network-analyzer sweep without CPU involvement. For each point it programs the IQ phase increment, waits for the IQ averaging engine to finish, reads the two 62-bit quadrature sums and emits them on a valid/ready result stream. It sits between the PS-side configuration registers and one IQ block's `addr/wen/ren/wdata/rdata/ack` port.

## Interface
- `PHASEBITS`, 32: width of frequency word / IQ phase increment
- `IDXBITS`, 16: width of point count and point index
- `TIMEOUT`, 16: cycles to wait for `m_ack_i` before flagging an error

- `clk_i` in 1: clock
- `rstn_i` in 1: reset; one clock, asynchronous, active-low
- `start_i` in 1: one-cycle pulse, starts a sweep; ignored while `busy_o`=1
- `abort_i` in 1: level/pulse, terminates the sweep
- `f_start_i` in PHASEBITS: first frequency word, sampled on accepted start
- `f_step_i` in PHASEBITS: frequency increment, sampled on accepted start
- `points_i` in IDXBITS: number of points, sampled on accepted start
- `m_addr_o` out 16: IQ register address
- `m_wen_o`, `m_ren_o` out 1: write / read strobe, one cycle each
- `m_wdata_o` out 32: write data
- `m_ack_i` in 1: IQ acknowledge
- `m_rdata_i` in 32: IQ read data
- `res_valid_o` out 1, `res_ready_i` in 1: result handshake
- `res_i_o`, `res_q_o` out 62: I/Q sums
- `res_idx_o` out IDXBITS: point index of result (0-based)
- `busy_o` out 1: sweep in progress
- `done_o` out 1: one-cycle pulse at normal sweep completion
- `err_o` out 1: sticky ack-timeout flag, cleared on next accepted start

## Operation
- All outputs reset to 0; internal freq, index, sums reset to 0.
- States: IDLE, WR_F, POLL, RD_IL, RD_IH, RD_QL, RD_QH, OUT, FIN.
- IDLE: on `start_i`, latch inputs, `freq<=f_start_i`, `idx<=0`, clear `err_o`, `busy_o<=1`. If `points_i`=0 go to FIN directly (no bus traffic); else WR_F.
- Bus access (every non-IDLE/OUT/FIN state): issue exactly one strobe cycle with address/data, then hold address and strobes low and wait for `m_ack_i`; `m_rdata_i` valid in the ack cycle. No new strobe before ack of the previous one.
- WR_F: write `freq` to 0x108 (zero-extended); this also restarts IQ averaging. On ack -> POLL.
- POLL: read 0x140; if `m_rdata_i[31]`=1 re-issue the read the cycle after ack; if 0 -> RD_IL.
- RD_IL/RD_IH/RD_QL/RD_QH read 0x140/0x144/0x148/0x14C; store bits [30:0]; `res_i_o={IH[30:0],IL[30:0]}`, `res_q_o={QH[30:0],QL[30:0]}`. After RD_QH ack -> OUT.
- OUT: `res_valid_o=1`, data and `res_idx_o=idx` stable until `res_ready_i`. On transfer: if `idx==points-1` -> FIN; else `idx<=idx+1`, `freq<=freq+f_step` (modulo 2^PHASEBITS, wraps silently) -> WR_F.
- FIN: pulse `done_o`, `busy_o<=0` -> IDLE.
- Timeout: counter starts at strobe; if no ack after TIMEOUT cycles, set `err_o`, go IDLE, `busy_o<=0`, no `done_o`.
- Abort: sampled each cycle while busy. In OUT or FIN-less states without outstanding access: go IDLE next cycle. With outstanding access: wait for ack (or timeout) first, then IDLE. Any pending result is dropped (`res_valid_o` falls). No `done_o`. Abort has priority over start in the same cycle.
- `start_i` during busy ignored; no queuing.

## Timing
- Start to first `m_wen_o`: 1 cycle (state register).
- IQ block acks 1 cycle after strobe; each access then takes 2 cycles; next strobe issued the cycle after ack.
- Minimum per point (averaging already finished at first poll, ready held high): WR 2 + POLL 2 + 4 reads 8 + OUT 1 = 13 cycles.
- `done_o` asserted 1 cycle after last result transfer; `busy_o` low the same cycle as `done_o`.
- `res_valid_o` registered; never depends combinationally on `res_ready_i`.

## Test plan
- Sweep f_start=0x1000, f_step=0x100, points=3, IQ model averaging 5 cycles -> writes 0x1000,0x1100,0x1200 to 0x108; 3 results idx 0,1,2; one `done_o`.
- Model sums I=0x2_0000_0001_2345, Q=-1 (62-bit) -> `res_i_o`/`res_q_o` reassembled exactly from 31-bit halves.
- points=0 -> no strobes, `done_o` 2 cycles after start, `busy_o` one cycle.
- f_start=0xFFFF_FF00, f_step=0x200, points=2 -> second write 0x0000_0100.
- `res_ready_i` low 20 cycles -> outputs stable, no bus traffic; model withholds ack at point 1 -> `err_o`=1 after 16 cycles, IDLE, no `done_o`.
- `abort_i` during POLL with outstanding read -> waits ack, IDLE, no result/done; async `rstn_i` mid-sweep -> all outputs 0 immediately.
